montgomery_domain_enter: RTL and testbench

- Sequential converter into the Montgomery domain: computes result = x·R mod m, where R = 2^k and k = m_bl_i.
- It is the entry-side counterpart of the pipelined Montgomery reduction block, which performs the exit side (x·R^-1 mod m).
- It sits in front of the Montgomery multiplier datapath.
- Implementation is a multiplier-free shift/conditional-subtract loop, one bit per clock, so it shares no DSP resources with the multiplier pipeline.

---
 rtl/mont_pkg.sv | 15 +
 rtl/mod_double_step.sv | 24 ++
 rtl/montgomery_domain_enter.sv | 114 +++++++++++
 tb/tb_montgomery_domain_enter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared Montgomery-domain definitions: FSM state encoding and default
// datapath width used by the domain-entry converter and its helpers.
package mont_pkg;

  // Default operand/modulus width for the Montgomery datapath.
  localparam int MONT_WIDTH = 64;

  // Domain-entry converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } mont_enter_state_t;

endpackage : mont_pkg

// File: rtl/mod_double_step.sv
// Combinational modular doubling: dbl = (2*acc) mod m, assuming acc < m.
// Widths are WIDTH+1 so the doubled value never overflows before the
// conditional subtract. Reusable for an R^2 precompute block.
module mod_double_step
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   dbl_o
);

  logic [WIDTH:0] dbl_raw;
  logic [WIDTH:0] m_ext;

  // acc < m < 2^WIDTH, so the shift into WIDTH+1 bits is lossless.
  assign dbl_raw = acc_i << 1;
  assign m_ext   = {1'b0, m_i};

  // 2*acc < 2m, so a single conditional subtract restores acc < m.
  assign dbl_o = (dbl_raw >= m_ext) ? (dbl_raw - m_ext) : dbl_raw;

endmodule : mod_double_step

// File: rtl/montgomery_domain_enter.sv
// Montgomery domain entry: result = x * 2^k mod m, k = bit length of m.
// One modular doubling per clock, no multipliers, so it never competes
// with the multiplier pipeline for DSP resources. Illegal moduli or bit
// lengths are rejected immediately with an err-qualified valid pulse.
module montgomery_domain_enter
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] m_bl_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] MAX_BL  = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mont_enter_state_t state_q, state_d;

  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] m_q;
  logic [CNT_W-1:0] cnt_q;

  logic             req_legal;
  logic             accept;
  logic [WIDTH:0]   x_ext;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   x_red;
  logic [WIDTH:0]   acc_dbl;

  // An odd modulus is necessarily nonzero, so m_i[0] covers both checks.
  assign req_legal = m_i[0] && (m_bl_i != '0) && (m_bl_i <= MAX_BL);
  assign accept    = (state_q == IDLE) && start_i && req_legal;

  // Contract allows x in [0, 2m); one subtract brings it under m.
  assign x_ext = {1'b0, x_i};
  assign m_ext = {1'b0, m_i};
  assign x_red = (x_ext >= m_ext) ? (x_ext - m_ext) : x_ext;

  assign busy_o = (state_q != IDLE);

  mod_double_step #(
    .WIDTH (WIDTH)
  ) u_dbl (
    .acc_i (acc_q),
    .m_i   (m_q),
    .dbl_o (acc_dbl)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: k doubling edges in SHIFT, then one DONE edge to publish.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_ONE) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latches, accumulator, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_o <= '0;
      valid_o  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (req_legal) begin
              m_q   <= m_i;
              acc_q <= x_red;
              cnt_q <= m_bl_i[CNT_W-1:0];
            end else begin
              result_o <= '0;
              valid_o  <= 1'b1;
              err_o    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_dbl;
          cnt_q <= cnt_q - CNT_ONE;
        end
        DONE: begin
          result_o <= acc_q[WIDTH-1:0];
          valid_o  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule : montgomery_domain_enter

// File: tb/tb_montgomery_domain_enter.sv
// Bench for montgomery_domain_enter: directed vector table, hand-written
// multi-cycle sequences, and random requests against a wide-arithmetic model.
module tb_montgomery_domain_enter;

  localparam int W = 64;
  localparam logic [63:0] MBIG = 64'hFFFF_FFFF_FFFF_FFC5;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [W-1:0]  x_i, m_i, m_bl_i;
  logic          busy_o, valid_o, err_o;
  logic [W-1:0]  result_o;

  int errors = 0;
  int checks = 0;

  montgomery_domain_enter #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .x_i      (x_i),
    .m_i      (m_i),
    .m_bl_i   (m_bl_i),
    .busy_o   (busy_o),
    .result_o (result_o),
    .valid_o  (valid_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] x;
    logic [63:0] m;
    logic [63:0] bl;
    logic [63:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // x * 2^k mod m using plain wide arithmetic.
  function automatic logic [63:0] ref_mont(input logic [63:0] x, input logic [63:0] m, input int k);
    logic [191:0] p;
    logic [191:0] r;
    p = {128'd0, x} << k;
    r = p % {128'd0, m};
    return r[63:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller sits at a negedge; the following posedge samples the request.
  task automatic issue(input logic [63:0] x, input logic [63:0] m, input logic [63:0] bl);
    x_i = x; m_i = m; m_bl_i = bl; start_i = 1'b1;
  endtask

  // Waits for the completion pulse, checking latency, busy span and outputs.
  // Inputs are scrambled right after the sampling edge; with disturb set a
  // second start is pulsed mid-run with different operands.
  task automatic collect(input logic [63:0] exp_res, input logic exp_err,
                         input int exp_lat, input int exp_busy,
                         input bit disturb, input string name);
    int  idx;
    int  busy_n;
    bit  seen;
    idx = 1; busy_n = 0; seen = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    x_i = rnd64(); m_i = rnd64(); m_bl_i = rnd64();
    while (idx <= 200) begin
      if (busy_o) busy_n++;
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
      if (disturb && idx == 2) begin
        start_i = 1'b1; x_i = 64'd7; m_i = 64'd97; m_bl_i = 64'd7;
      end
      if (disturb && idx == 3) start_i = 1'b0;
      @(negedge clk_i);
      idx++;
    end
    chk({name, " valid_seen"}, 64'(seen), 64'd1);
    chk({name, " latency"}, 64'(idx), 64'(exp_lat));
    chk({name, " busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    chk({name, " result"}, result_o, exp_res);
    chk({name, " err"}, 64'(err_o), 64'(exp_err));
  endtask

  // Counts completion pulses over n cycles; none are expected.
  task automatic quiet(input int n, input string name);
    int pulses;
    int errs;
    pulses = 0; errs = 0;
    repeat (n) begin
      @(negedge clk_i);
      if (valid_o) pulses++;
      if (err_o) errs++;
    end
    chk({name, " no_extra_valid"}, 64'(pulses), 64'd0);
    chk({name, " no_err"}, 64'(errs), 64'd0);
  endtask

  initial begin
    vecs[0] = '{x: 64'd5,  m: 64'd13, bl: 64'd4,  res: 64'h2,  err: 1'b0};
    vecs[1] = '{x: 64'd15, m: 64'd13, bl: 64'd4,  res: 64'h6,  err: 1'b0};
    vecs[2] = '{x: 64'd0,  m: 64'd13, bl: 64'd4,  res: 64'h0,  err: 1'b0};
    vecs[3] = '{x: 64'd1,  m: MBIG,   bl: 64'd64, res: 64'h3B, err: 1'b0};
    vecs[4] = '{x: 64'd1,  m: 64'd1,  bl: 64'd1,  res: 64'h0,  err: 1'b0};
    vecs[5] = '{x: 64'd5,  m: 64'd13, bl: 64'd0,  res: 64'h0,  err: 1'b1};
    vecs[6] = '{x: 64'd5,  m: 64'd12, bl: 64'd4,  res: 64'h0,  err: 1'b1};
    vecs[7] = '{x: 64'd3,  m: 64'd13, bl: 64'd65, res: 64'h0,  err: 1'b1};
    vecs[8] = '{x: 64'd0,  m: 64'd0,  bl: 64'd1,  res: 64'h0,  err: 1'b1};

    rst_ni = 1'b0; start_i = 1'b0; x_i = '0; m_i = '0; m_bl_i = '0;
    repeat (3) @(negedge clk_i);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset valid", 64'(valid_o), 64'd0);
    chk("reset err", 64'(err_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed table; illegal requests complete on the sampling edge.
    for (int i = 0; i < 9; i++) begin
      int lat;
      int bsy;
      lat = vecs[i].err ? 1 : int'(vecs[i].bl) + 2;
      bsy = vecs[i].err ? 0 : int'(vecs[i].bl) + 1;
      issue(vecs[i].x, vecs[i].m, vecs[i].bl);
      collect(vecs[i].res, vecs[i].err, lat, bsy, 1'b0, $sformatf("vec%0d", i));
      quiet(2, $sformatf("vec%0d", i));
    end

    // Start pulsed mid-run with other operands must be ignored.
    issue(64'd5, 64'd13, 64'd4);
    collect(64'h2, 1'b0, 6, 5, 1'b1, "busy_start");
    quiet(12, "busy_start");

    // Back-to-back: the next request is issued in the valid cycle.
    issue(64'd1, MBIG, 64'd64);
    collect(64'h3B, 1'b0, 66, 65, 1'b0, "b2b_first");
    issue(MBIG - 64'd1, MBIG, 64'd64);
    collect(64'hFFFF_FFFF_FFFF_FF8A, 1'b0, 66, 65, 1'b0, "b2b_second");
    quiet(2, "b2b");

    // Asynchronous reset in the middle of SHIFT.
    issue(64'd1, MBIG, 64'd64);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("midreset busy", 64'(busy_o), 64'd0);
    chk("midreset valid", 64'(valid_o), 64'd0);
    chk("midreset err", 64'(err_o), 64'd0);
    chk("midreset result", result_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    quiet(80, "after_reset");
    issue(64'd15, 64'd13, 64'd4);
    collect(64'h6, 1'b0, 6, 5, 1'b0, "post_reset");

    // Random legal requests against the wide-arithmetic model.
    for (int n = 0; n < 25; n++) begin
      int          k;
      logic [63:0] mask, m, x;
      logic [64:0] two_m;
      k    = $urandom_range(1, 64);
      mask = (k == 64) ? '1 : ((64'd1 << k) - 64'd1);
      m    = (rnd64() & mask) | (64'd1 << (k - 1)) | 64'd1;
      two_m = {m, 1'b0};
      x    = 64'({1'b0, rnd64()} % two_m);
      issue(x, m, 64'(k));
      collect(ref_mont(x, m, k), 1'b0, k + 2, k + 1, 1'b0, $sformatf("rnd%0d", n));
    end
    quiet(2, "rnd_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_montgomery_domain_enter
